// File: rtl/read_arbiter_pkg.sv
// Shared types and helpers for the egress read arbiter.
package read_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StRead
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A programmed weight of zero still earns one packet per round.
  function automatic int unsigned eff_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/read_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after start_i, wrapping.
module rr_pick #(
  parameter int unsigned NumPorts = 16,
  parameter int unsigned IdxW     = 4
) (
  input  logic [NumPorts-1:0] req_i,
  input  logic [IdxW-1:0]     start_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [IdxW-1:0]     idx_o,
  output logic                any_o
);

  always_comb begin
    int unsigned p;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    p     = 0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      p = 32'(start_i) + k;
      if (p >= NumPorts) p = p - NumPorts;
      if (!any_o && req_i[p[IdxW-1:0]]) begin
        any_o                = 1'b1;
        gnt_o[p[IdxW-1:0]]   = 1'b1;
        idx_o                = p[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/read_arbiter.sv
// Egress read arbiter: grants one port per packet (SP or WRR), issues one SRAM read per
// cycle for it and returns the data with per-port vld/sop/eop framing.
module read_arbiter
  import read_arbiter_pkg::*;
#(
  parameter int unsigned num_of_ports       = 16,
  parameter int unsigned arbiter_data_width = 256,
  parameter int unsigned len_width          = 7,
  parameter int unsigned weight_width       = 4,
  parameter int unsigned rd_lat             = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sp0_wrr1,
  input  logic [num_of_ports-1:0]                 req,
  input  logic [num_of_ports-1:0]                 ready,
  input  logic [num_of_ports*len_width-1:0]       head_len,
  input  logic [num_of_ports*weight_width-1:0]    weight,
  output logic                                    rd_en,
  output logic [idx_width(num_of_ports)-1:0]      rd_port,
  input  logic [arbiter_data_width-1:0]           rd_data,
  output logic [num_of_ports-1:0]                 grant,
  output logic [arbiter_data_width-1:0]           data_out,
  output logic [num_of_ports-1:0]                 vld,
  output logic [num_of_ports-1:0]                 sop,
  output logic [num_of_ports-1:0]                 eop
);

  localparam int unsigned N    = num_of_ports;
  localparam int unsigned IW   = idx_width(num_of_ports);
  localparam int unsigned Tail = rd_lat - 1;

  logic [len_width-1:0]    head_len_a [N];
  logic [weight_width-1:0] weight_a   [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign head_len_a[i] = head_len[i*len_width +: len_width];
    assign weight_a[i]   = weight[i*weight_width +: weight_width];
  end

  state_e                  state_q, state_d;
  logic [IW-1:0]           gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [weight_width-1:0] used_q, used_d, used_eff;
  logic [len_width-1:0]    rem_q, rem_d;
  logic [N-1:0]            grant_q, grant_d;
  logic                    first_q, first_d;
  logic                    mode_q, mode_d;

  logic [N-1:0]  eligible, pick_gnt;
  logic [IW-1:0] pick_start, pick_idx, ptr_plus1, sel;
  logic          pick_any, last_issue;

  assign eligible   = req & ready;
  assign ptr_plus1  = (ptr_q == IW'(N - 1)) ? '0 : ptr_q + 1'b1;
  assign pick_start = sp0_wrr1 ? ptr_plus1 : '0;
  assign used_eff   = (sp0_wrr1 != mode_q) ? '0 : used_q;

  rr_pick #(
    .NumPorts(N),
    .IdxW    (IW)
  ) u_pick (
    .req_i  (eligible),
    .start_i(pick_start),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign rd_en      = (state_q == StRead) && ready[gnt_idx_q];
  assign rd_port    = rd_en ? gnt_idx_q : '0;
  assign last_issue = rd_en && (rem_q == len_width'(1));

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    used_d    = used_q;
    rem_d     = rem_q;
    grant_d   = grant_q;
    first_d   = first_q;
    mode_d    = mode_q;
    sel       = pick_idx;
    unique case (state_q)
      StIdle: begin
        if (|eligible) state_d = StArb;
      end
      StArb: begin
        mode_d = sp0_wrr1;
        used_d = used_eff;
        if (pick_any) begin
          if (sp0_wrr1) begin
            // Stay on ptr while it still has credit, else rotate to the next eligible port.
            if (eligible[ptr_q] &&
                (32'(used_eff) < eff_weight(32'(weight_a[ptr_q])))) begin
              sel    = ptr_q;
              used_d = used_eff + 1'b1;
            end else begin
              sel    = pick_idx;
              ptr_d  = pick_idx;
              used_d = weight_width'(1);
            end
          end
          gnt_idx_d    = sel;
          rem_d        = (head_len_a[sel] == '0) ? len_width'(1) : head_len_a[sel];
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          first_d      = 1'b1;
          state_d      = StRead;
        end else begin
          state_d = StIdle;
        end
      end
      StRead: begin
        if (rd_en) begin
          rem_d   = rem_q - 1'b1;
          first_d = 1'b0;
          if (last_issue) begin
            grant_d = '0;
            state_d = StArb;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      used_q    <= '0;
      rem_q     <= '0;
      grant_q   <= '0;
      first_q   <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      used_q    <= used_d;
      rem_q     <= rem_d;
      grant_q   <= grant_d;
      first_q   <= first_d;
      mode_q    <= mode_d;
    end
  end

  // Return pipeline: one entry per issued word, aligned with the SRAM read latency.
  logic [rd_lat-1:0] pv_q, pf_q, pl_q;
  logic [IW-1:0]     pp_q [rd_lat];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q <= '0;
      pf_q <= '0;
      pl_q <= '0;
      for (int k = 0; k < int'(rd_lat); k++) pp_q[k] <= '0;
    end else begin
      pv_q[0] <= rd_en;
      pf_q[0] <= rd_en & first_q;
      pl_q[0] <= last_issue;
      pp_q[0] <= gnt_idx_q;
      for (int k = 1; k < int'(rd_lat); k++) begin
        pv_q[k] <= pv_q[k-1];
        pf_q[k] <= pf_q[k-1];
        pl_q[k] <= pl_q[k-1];
        pp_q[k] <= pp_q[k-1];
      end
    end
  end

  logic [N-1:0]                  vld_q, sop_q, eop_q;
  logic [arbiter_data_width-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      sop_q  <= '0;
      eop_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q <= '0;
      sop_q <= '0;
      eop_q <= '0;
      if (pv_q[Tail]) begin
        vld_q[pp_q[Tail]] <= 1'b1;
        sop_q[pp_q[Tail]] <= pf_q[Tail];
        eop_q[pp_q[Tail]] <= pl_q[Tail];
        data_q            <= rd_data;
      end
    end
  end

  assign grant    = grant_q;
  assign vld      = vld_q;
  assign sop      = sop_q;
  assign eop      = eop_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_read_arbiter.sv
// Directed and random stimulus for read_arbiter, checked every cycle against a
// packet-level reference model.
module tb_read_arbiter;

  localparam int N  = 16;
  localparam int DW = 256;
  localparam int LW = 7;
  localparam int WW = 4;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            sp0_wrr1;
  logic [N-1:0]    req, ready;
  logic [N*LW-1:0] head_len;
  logic [N*WW-1:0] weight;
  logic            rd_en;
  logic [3:0]      rd_port;
  logic [DW-1:0]   rd_data;
  logic [N-1:0]    grant, vld, sop, eop;
  logic [DW-1:0]   data_out;

  read_arbiter #(
    .num_of_ports      (N),
    .arbiter_data_width(DW),
    .len_width         (LW),
    .weight_width      (WW),
    .rd_lat            (RL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sp0_wrr1(sp0_wrr1),
    .req     (req),
    .ready   (ready),
    .head_len(head_len),
    .weight  (weight),
    .rd_en   (rd_en),
    .rd_port (rd_port),
    .rd_data (rd_data),
    .grant   (grant),
    .data_out(data_out),
    .vld     (vld),
    .sop     (sop),
    .eop     (eop)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 arbitrating, 2 reading a packet.
  typedef struct {
    int due;
    int port;
    bit first;
    bit last;
  } ret_t;

  ret_t          rq[$];
  int            m_phase, m_g, m_rem, m_ptr, m_used, cyc;
  bit            m_first, m_mode;
  logic [DW-1:0] m_dout, rd_prev;

  int           gq[$];
  logic [N-1:0] prev_grant;
  int           n_rden, n_eop5, n_vld;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lenof(input int p);
    return int'(head_len[p*LW +: LW]);
  endfunction

  function automatic int wt_eff(input int p);
    int w;
    w = int'(weight[p*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int first_set(input logic [N-1:0] el, input int start);
    for (int k = 0; k < N; k++) if (el[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    rq.delete();
    m_phase = 0; m_g = 0; m_rem = 0; m_ptr = 0; m_used = 0;
    m_first = 1'b0; m_mode = 1'b0; m_dout = '0;
  endtask

  task automatic set_len(input int p, input int v);
    head_len[p*LW +: LW] = LW'(v);
  endtask

  task automatic set_w(input int p, input int v);
    weight[p*WW +: WW] = WW'(v);
  endtask

  // One clock: drive rd_data, check outputs against the model, then advance the model.
  task automatic step();
    logic [N-1:0] e_vld, e_sop, e_eop, e_grant, el;
    logic         e_rden;
    logic [3:0]   e_port;
    ret_t         r;
    int           g;
    for (int k = 0; k < DW / 32; k++) rd_data[k*32 +: 32] = $urandom();
    #1;
    e_vld = '0; e_sop = '0; e_eop = '0; e_grant = '0; e_rden = 1'b0; e_port = '0;
    if (!rst) begin
      model_reset();
    end else begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        e_vld[r.port] = 1'b1;
        e_sop[r.port] = r.first;
        e_eop[r.port] = r.last;
        m_dout        = rd_prev;
      end
      if (m_phase == 2) begin
        e_grant[m_g] = 1'b1;
        e_rden       = ready[m_g];
        if (e_rden) e_port = 4'(m_g);
      end
    end
    chk("rd_en", DW'(rd_en), DW'(e_rden));
    chk("rd_port", DW'(rd_port), DW'(e_port));
    chk("grant", DW'(grant), DW'(e_grant));
    chk("vld", DW'(vld), DW'(e_vld));
    chk("sop", DW'(sop), DW'(e_sop));
    chk("eop", DW'(eop), DW'(e_eop));
    chk("data_out", data_out, m_dout);

    if (rd_en === 1'b1) n_rden++;
    if (eop[5] === 1'b1) n_eop5++;
    if (|vld) n_vld++;
    if (grant !== '0 && prev_grant === '0)
      for (int k = 0; k < N; k++) if (grant[k] === 1'b1) gq.push_back(k);
    prev_grant = grant;

    if (rst) begin
      el = req & ready;
      case (m_phase)
        0: if (el != '0) m_phase = 1;
        1: begin
          if (sp0_wrr1 != m_mode) m_used = 0;
          m_mode = sp0_wrr1;
          if (el == '0) begin
            m_phase = 0;
          end else begin
            if (!sp0_wrr1) begin
              g = first_set(el, 0);
            end else if (el[m_ptr] && m_used < wt_eff(m_ptr)) begin
              g = m_ptr;
              m_used++;
            end else begin
              g      = first_set(el, (m_ptr + 1) % N);
              m_ptr  = g;
              m_used = 1;
            end
            m_g     = g;
            m_rem   = (lenof(g) == 0) ? 1 : lenof(g);
            m_first = 1'b1;
            m_phase = 2;
          end
        end
        default: begin
          if (ready[m_g]) begin
            rq.push_back('{cyc + RL + 1, m_g, m_first, m_rem == 1});
            m_first = 1'b0;
            m_rem--;
            if (m_rem == 0) m_phase = 1;
          end
        end
      endcase
    end
    rd_prev = rd_data;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int exp_a[2];
    int exp_b[6];
    int exp_d[3];
    int exp_f[4];
    exp_a = '{1, 2};
    exp_b = '{0, 0, 3, 0, 0, 3};
    exp_d = '{0, 15, 0};
    exp_f = '{7, 11, 7, 11};

    rst = 1'b0; sp0_wrr1 = 1'b0; req = '0; ready = '1;
    for (int p = 0; p < N; p++) begin set_len(p, 1); set_w(p, 1); end
    rd_data = '0; rd_prev = '0; prev_grant = '0; cyc = 0;
    n_rden = 0; n_eop5 = 0; n_vld = 0;
    model_reset();
    @(negedge clk);
    repeat (3) step();
    rst = 1'b1;

    // SP: port 1 (3 words) then port 2
    set_len(1, 3); set_len(2, 2); req = 16'h0006;
    repeat (3) step();
    req = 16'h0004;
    repeat (5) step();
    req = '0;
    repeat (6) step();
    for (int k = 0; k < 2; k++) chk("sp_order", DW'((k < gq.size()) ? gq[k] : -1), DW'(exp_a[k]));

    // WRR weights 2:1
    gq.delete(); sp0_wrr1 = 1'b1; set_w(0, 2); set_w(3, 1); set_len(0, 1); set_len(3, 1);
    req = 16'h0009;
    repeat (14) step();
    req = '0;
    repeat (4) step();
    for (int k = 0; k < 6; k++) chk("wrr_order", DW'((k < gq.size()) ? gq[k] : -1), DW'(exp_b[k]));

    // Backpressure on port 5 after the 2nd issue
    sp0_wrr1 = 1'b0; set_len(5, 4); n_rden = 0; n_eop5 = 0; req = 16'h0020;
    repeat (4) step();
    ready[5] = 1'b0;
    repeat (2) step();
    ready[5] = 1'b1; req = '0;
    repeat (8) step();
    chk("bp_rden_count", DW'(n_rden), DW'(4));
    chk("bp_eop_count", DW'(n_eop5), DW'(1));

    // Wrap-around from ptr=15
    sp0_wrr1 = 1'b1;
    for (int p = 0; p < N; p++) set_w(p, 1);
    set_len(15, 1); set_len(0, 1); req = 16'h8000;
    repeat (3) step();
    req = '0;
    repeat (4) step();
    gq.delete(); req = 16'h8001;
    repeat (7) step();
    req = '0;
    repeat (4) step();
    for (int k = 0; k < 3; k++) chk("wrap_order", DW'((k < gq.size()) ? gq[k] : -1), DW'(exp_d[k]));

    // Reset during the 3rd word of an 8-word packet
    sp0_wrr1 = 1'b0; set_len(2, 8); req = 16'h0004;
    repeat (4) step();
    rst = 1'b0; req = '0;
    repeat (3) step();
    rst = 1'b1; n_vld = 0;
    repeat (8) step();
    chk("rst_no_stale_vld", DW'(n_vld), DW'(0));

    // Weight 0 behaves as 1, single-word packets
    sp0_wrr1 = 1'b1; set_w(7, 0); set_w(11, 1); set_len(7, 1); set_len(11, 1);
    gq.delete(); req = 16'h0880;
    repeat (9) step();
    req = '0;
    repeat (5) step();
    for (int k = 0; k < 4; k++) chk("w0_order", DW'((k < gq.size()) ? gq[k] : -1), DW'(exp_f[k]));

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      req   = N'($urandom() & $urandom());
      ready = N'($urandom() | $urandom());
      for (int p = 0; p < N; p++) set_len(p, int'($urandom_range(0, 5)));
      if (i % 50 == 0) for (int p = 0; p < N; p++) set_w(p, int'($urandom_range(0, 3)));
      if (i % 70 == 0) sp0_wrr1 = ~sp0_wrr1;
      rst = (i >= 400 && i < 402) ? 1'b0 : 1'b1;
      step();
    end
    rst = 1'b1; req = '0; ready = '1;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
